// File: rtl/fx2_fifo_reader.sv
// Purpose : drain an FX2 slave-FIFO OUT endpoint into a 16x8 FWFT FIFO.
// Latency : byte sampled on the last SLRD-low edge is on rx_data the next cycle (FIFO empty).
// Backpressure: rx_ready low fills the FIFO; at 16 entries no new SLRD strobe is started.
//
// Ports (fx2_rx_fifo): clk/rst, push_vld/push_dat write side, pop_rdy read side,
// head_vld/head_dat first-word-fall-through head, level occupancy 0..2^AW.
module fx2_rx_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_vld,
  input  logic [DW-1:0] push_dat,
  input  logic          pop_rdy,
  output logic [DW-1:0] head_dat,
  output logic          head_vld,
  output logic [AW:0]   level
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop   = pop_rdy && (cnt_q != '0);
    // a simultaneous pop frees the slot, so push is still legal at full
    do_push  = push_vld && ((cnt_q != FULL_CNT) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // storage needs no reset: the head is masked to zero while empty
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat;
    end
  end

  assign head_vld = (cnt_q != '0);
  assign head_dat = head_vld ? mem_q[rd_ptr_q] : '0;
  assign level    = cnt_q;
endmodule

// Purpose : FX2 slave-FIFO read master (SLOE/SLRD strobing) feeding an rx valid/ready stream.
// Latency : one byte per SLRD_LOW+SLRD_HIGH+1 cycles back-to-back; rx_data valid 1 cycle after capture.
// Backpressure: a strobe starts only when the internal FIFO has room; strobes in flight always complete.
//
// Ports: sys_clk/sys_rst (sync, active high); enable; cy_D + FLAGA (empty flag, async, active low)
// from the FX2; SLRD/SLOE/FIFOADR to the FX2; rx_data/rx_valid/rx_ready stream; level; byte_count.
module fx2_fifo_reader #(
  parameter int unsigned SLRD_LOW  = 3,
  parameter int unsigned SLRD_HIGH = 3,
  parameter logic [1:0]  EP_ADDR   = 2'b00
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        enable,
  input  logic [7:0]  cy_D,
  input  logic        cy_to_fpga_CTL0_FLAGA,
  output logic        cy_from_fpga_RDY0_SLRD,
  output logic        cy_from_fpga_A2_SLOE,
  output logic        cy_from_fpga_A4_FIFOADR0,
  output logic        cy_from_fpga_A5_FIFOADR1,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [4:0]  level,
  output logic [15:0] byte_count
);
  typedef enum logic [2:0] {IDLE, OE, CHECK, RD_LOW, RD_HIGH} state_t;

  localparam logic [3:0] LOW_LAST  = 4'(SLRD_LOW - 1);
  localparam logic [3:0] HIGH_LAST = 4'(SLRD_HIGH - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] byte_count_q, byte_count_d;
  logic        flag_meta_q, flag_meta_d;
  logic        flag_ne_q, flag_ne_d;
  logic        slrd_q, slrd_d;
  logic        sloe_q, sloe_d;
  logic        push_vld;

  // FLAGA is asynchronous to sys_clk; nothing else looks at the raw pin
  assign flag_meta_d = cy_to_fpga_CTL0_FLAGA;
  assign flag_ne_d   = flag_meta_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    byte_count_d = byte_count_q;
    push_vld     = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = OE;
      end
      OE: begin
        state_d = CHECK;
      end
      CHECK: begin
        cnt_d = '0;
        if (!enable) begin
          state_d = IDLE;
        end else if (flag_ne_q && (level <= 5'd15)) begin
          state_d = RD_LOW;
        end
      end
      RD_LOW: begin
        // enable is ignored here so a strobe is never cut short
        if (cnt_q == LOW_LAST) begin
          push_vld     = 1'b1;
          byte_count_d = byte_count_q + 16'd1;
          cnt_d        = '0;
          state_d      = RD_HIGH;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RD_HIGH: begin
        if (cnt_q == HIGH_LAST) begin
          cnt_d   = '0;
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // pins are registered from the next state so they change glitch-free
    // on the same edge the state does
    slrd_d = (state_d != RD_LOW);
    sloe_d = (state_d == IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      byte_count_q <= '0;
      flag_meta_q  <= 1'b0;
      flag_ne_q    <= 1'b0;
      slrd_q       <= 1'b1;
      sloe_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      byte_count_q <= byte_count_d;
      flag_meta_q  <= flag_meta_d;
      flag_ne_q    <= flag_ne_d;
      slrd_q       <= slrd_d;
      sloe_q       <= sloe_d;
    end
  end

  fx2_rx_fifo #(.DW(8), .AW(4)) u_rx_fifo (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .push_vld (push_vld),
    .push_dat (cy_D),
    .pop_rdy  (rx_ready),
    .head_dat (rx_data),
    .head_vld (rx_valid),
    .level    (level)
  );

  assign cy_from_fpga_RDY0_SLRD   = slrd_q;
  assign cy_from_fpga_A2_SLOE     = sloe_q;
  assign cy_from_fpga_A4_FIFOADR0 = EP_ADDR[0];
  assign cy_from_fpga_A5_FIFOADR1 = EP_ADDR[1];
  assign byte_count               = byte_count_q;
endmodule

// File: tb/tb_fx2_fifo_reader.sv
// Purpose : self-checking bench for fx2_fifo_reader against an FX2 + stream reference model.
// Latency : n/a (bench).
// Backpressure: rx_ready driven directly and randomly by the bench.
module tb_fx2_fifo_reader;
  localparam int L = 3;
  localparam int H = 3;
  localparam logic [1:0] EP = 2'b10;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        enable;
  logic [7:0]  cy_D = 8'h00;
  logic        flaga = 1'b0;
  logic        slrd, sloe, fa0, fa1;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [4:0]  level;
  logic [15:0] byte_count;

  always #10 sys_clk = ~sys_clk;

  fx2_fifo_reader #(.SLRD_LOW(L), .SLRD_HIGH(H), .EP_ADDR(EP)) dut (
    .sys_clk                  (sys_clk),
    .sys_rst                  (sys_rst),
    .enable                   (enable),
    .cy_D                     (cy_D),
    .cy_to_fpga_CTL0_FLAGA    (flaga),
    .cy_from_fpga_RDY0_SLRD   (slrd),
    .cy_from_fpga_A2_SLOE     (sloe),
    .cy_from_fpga_A4_FIFOADR0 (fa0),
    .cy_from_fpga_A5_FIFOADR1 (fa1),
    .rx_data                  (rx_data),
    .rx_valid                 (rx_valid),
    .rx_ready                 (rx_ready),
    .level                    (level),
    .byte_count               (byte_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: bytes held by the FX2 endpoint, bytes that have left
  // the FX2 but not yet been consumed downstream, and running totals.
  logic [7:0]  fx2_q[$];
  logic [7:0]  exp_q[$];
  logic [15:0] exp_count = 16'd0;
  logic        mon_en = 1'b0;
  logic        slrd_prev = 1'b1;
  int          low_run = 0;
  int          pulses = 0;
  int          rx_got = 0;
  int          cyc = 0;
  int          last_start = -1;
  int          gap_last = 0;

  always @(negedge sys_clk) begin
    cyc++;
    if (mon_en) begin
      if (slrd === 1'b0) begin
        if (slrd_prev) begin
          check("strobe_src_nonempty", fx2_q.size() != 0, 1'b1);
          check("strobe_fifo_room", exp_q.size() <= 15, 1'b1);
          if (last_start >= 0) begin
            gap_last = cyc - last_start;
            check("strobe_gap_min", gap_last >= L + H + 1, 1'b1);
          end
          last_start = cyc;
        end
        low_run++;
        check("sloe_low_in_read", sloe, 1'b0);
      end else if (!slrd_prev) begin
        // strobe finished: FX2 hands out its head byte
        check("strobe_len", low_run, L);
        pulses++;
        if (fx2_q.size() != 0) exp_q.push_back(fx2_q.pop_front());
        exp_count++;
        low_run = 0;
      end
      slrd_prev = slrd;
      check("level", level, exp_q.size());
      check("rx_valid", rx_valid, exp_q.size() != 0);
      check("byte_count", byte_count, exp_count);
      if (rx_valid === 1'b1 && rx_ready && exp_q.size() != 0) begin
        check("rx_data", rx_data, exp_q.pop_front());
        rx_got++;
      end
    end
    flaga = (fx2_q.size() != 0);
    cy_D  = (fx2_q.size() != 0) ? fx2_q[0] : 8'h00;
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_count  = 16'd0;
    low_run    = 0;
    slrd_prev  = 1'b1;
    last_start = -1;
  endtask

  task automatic load_random(input int n);
    for (int i = 0; i < n; i++) fx2_q.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    int p0;
    sys_rst  = 1'b1;
    enable   = 1'b0;
    rx_ready = 1'b0;

    // reset state
    step(); step();
    check("rst_slrd", slrd, 1'b1);
    check("rst_sloe", sloe, 1'b1);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_level", level, 5'd0);
    check("rst_byte_count", byte_count, 16'd0);
    check("rst_fifoadr0", fa0, EP[0]);
    check("rst_fifoadr1", fa1, EP[1]);
    sys_rst = 1'b0;
    step();
    check("idle_fifoadr1", fa1, EP[1]);
    check("idle_sloe", sloe, 1'b1);
    clear_model();
    mon_en = 1'b1;

    // three known bytes, consumer always ready
    fx2_q.push_back(8'h11); fx2_q.push_back(8'h22); fx2_q.push_back(8'h33);
    enable = 1'b1; rx_ready = 1'b1;
    for (int i = 0; i < 300 && pulses < 3; i++) step();
    repeat (20) step();
    check("t1_pulses", pulses, 3);
    check("t1_rx_got", rx_got, 3);
    check("t1_byte_count", byte_count, 16'd3);
    check("t1_gap", gap_last, L + H + 1);
    check("t1_sloe_check", sloe, 1'b0);
    check("t1_slrd_idle", slrd, 1'b1);

    // endpoint empty: output enabled but no strobes
    repeat (30) step();
    check("t2_pulses", pulses, 3);
    check("t2_sloe", sloe, 1'b0);
    check("t2_slrd", slrd, 1'b1);
    check("t2_level", level, 5'd0);
    check("t2_rx_valid", rx_valid, 1'b0);

    // consumer stalled with 20 bytes waiting: stop at 16
    rx_ready = 1'b0;
    p0 = pulses;
    load_random(20);
    for (int i = 0; i < 400 && pulses < p0 + 16; i++) step();
    repeat (30) step();
    check("t3_reads", pulses - p0, 16);
    check("t3_level_full", level, 5'd16);
    check("t3_slrd_hold", slrd, 1'b1);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    repeat (40) step();
    check("t3_one_more", pulses - p0, 17);
    check("t3_level_refill", level, 5'd16);
    for (int i = 0; i < 1000 && (fx2_q.size() != 0 || exp_q.size() != 0); i++) begin
      rx_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rx_ready = 1'b1;
    repeat (3) step();
    check("t3_drained", exp_q.size() + fx2_q.size(), 0);
    check("t3_level_empty", level, 5'd0);

    // randomized traffic, backpressure and enable toggling
    for (int i = 0; i < 1500; i++) begin
      rx_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if ($urandom_range(0, 24) == 0 && fx2_q.size() < 40) load_random($urandom_range(1, 6));
      step();
    end
    enable = 1'b1; rx_ready = 1'b1;
    for (int i = 0; i < 2000 && (fx2_q.size() != 0 || exp_q.size() != 0); i++) step();
    repeat (3) step();
    check("t4_drained", exp_q.size() + fx2_q.size(), 0);

    // enable drops in the second SLRD-low cycle
    p0 = pulses;
    load_random(1);
    for (int i = 0; i < 50 && slrd !== 1'b0; i++) step();
    check("t5_strobe_seen", slrd, 1'b0);
    step();
    enable = 1'b0;
    for (int i = 0; i < 20 && sloe !== 1'b1; i++) step();
    check("t5_pulse_done", pulses - p0, 1);
    check("t5_sloe_idle", sloe, 1'b1);
    check("t5_slrd_idle", slrd, 1'b1);
    repeat (3) step();
    check("t5_level", level, 5'd0);

    // reset lands in the second SLRD-low cycle
    mon_en = 1'b0;
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    clear_model();
    mon_en = 1'b1;
    enable = 1'b1;
    load_random(1);
    for (int i = 0; i < 50 && slrd !== 1'b0; i++) step();
    check("t6_strobe_seen", slrd, 1'b0);
    step();
    mon_en = 1'b0;
    sys_rst = 1'b1;
    step();
    check("t6_slrd_release", slrd, 1'b1);
    check("t6_level", level, 5'd0);
    check("t6_byte_count", byte_count, 16'd0);
    step();
    sys_rst = 1'b0;
    clear_model();
    mon_en = 1'b1;
    for (int i = 0; i < 100 && fx2_q.size() != 0; i++) step();
    repeat (5) step();
    check("t6_reread_count", byte_count, 16'd1);

    // byte_count wrap from a preset value
    enable = 1'b0;
    repeat (15) step();
    force dut.byte_count_q = 16'hFFFE;
    exp_count = 16'hFFFE;
    step();
    release dut.byte_count_q;
    step();
    check("t7_preset", byte_count, 16'hFFFE);
    p0 = pulses;
    enable = 1'b1;
    load_random(3);
    for (int i = 0; i < 100 && pulses < p0 + 2; i++) step();
    check("t7_wrap_zero", byte_count, 16'h0000);
    for (int i = 0; i < 100 && pulses < p0 + 3; i++) step();
    check("t7_after_wrap", byte_count, 16'h0001);

    // push and pop on the same edge at level 8
    rx_ready = 1'b0;
    repeat (10) step();
    load_random(8);
    for (int i = 0; i < 200 && level !== 5'd8; i++) step();
    repeat (10) step();
    check("t8_level_pre", level, 5'd8);
    load_random(1);
    for (int i = 0; i < 50 && slrd !== 1'b0; i++) step();
    check("t8_strobe_seen", slrd, 1'b0);
    step(); step();
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    check("t8_level_same", level, 5'd8);
    repeat (10) step();
    check("t8_level_hold", level, 5'd8);
    rx_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
    repeat (3) step();
    check("t8_drained", level, 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fx2_fifo_reader.md
FX2_FIFO_READER -- requirements
Module: fx2_fifo_reader

Interface
REQ-001 Parameter SLRD_LOW, default 3, meaning SLRD low time in sys_clk cycles (range 2..15).
REQ-002 Parameter SLRD_HIGH, default 3, meaning SLRD high recovery in cycles (range 3..15; covers the flag synchronizer).
REQ-003 Parameter EP_ADDR, default 2'b00, meaning FX2 FIFOADR[1:0] endpoint select (EP2).
REQ-004 sys_clk  in  1  sole clock, 50 MHz.
REQ-005 sys_rst  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  1 = drain the FX2 OUT endpoint.
REQ-007 cy_D  in  8  FX2 FD[7:0] data bus (read direction only).
REQ-008 cy_to_fpga_CTL0_FLAGA  in  1  FX2 empty flag, active low (0 = endpoint empty); asynchronous.
REQ-009 cy_from_fpga_RDY0_SLRD  out  1  SLRD, active low.
REQ-010 cy_from_fpga_A2_SLOE  out  1  SLOE, active low.
REQ-011 cy_from_fpga_A4_FIFOADR0 / cy_from_fpga_A5_FIFOADR1  out  1 each  EP_ADDR[0] / EP_ADDR[1], constant.
REQ-012 rx_data  out  8  head byte of the internal FIFO.
REQ-013 rx_valid  out  1  internal FIFO non-empty.
REQ-014 rx_ready  in  1  consumer accepts rx_data.
REQ-015 level  out  5  internal FIFO occupancy, 0..16.
REQ-016 byte_count  out  16  bytes read from FX2 since reset, wraps at 65535 -> 0.

Function
REQ-017 FLAGA SHALL pass through a 2-FF synchronizer; flag_ne = synchronized FLAGA. No other logic SHALL use raw FLAGA.
REQ-018 FSM states SHALL be IDLE, OE, CHECK, RD_LOW, RD_HIGH.
REQ-019 IDLE: SLOE=1, SLRD=1; enable=1 -> OE.
REQ-020 OE: SLOE=0 for exactly 1 cycle, then CHECK.
REQ-021 CHECK: enable=0 -> IDLE; else flag_ne=1 and level<=15 -> RD_LOW; else stay in CHECK.
REQ-022 RD_LOW: SLRD=0 for SLRD_LOW cycles; on the last cycle cy_D SHALL be captured and pushed, and byte_count incremented; then RD_HIGH.
REQ-023 RD_HIGH: SLRD=1 for SLRD_HIGH cycles, then CHECK.
REQ-024 SLOE SHALL be 0 in every state except IDLE.
REQ-025 An enable drop during RD_LOW or RD_HIGH SHALL NOT truncate the strobe; the strobe completes, then CHECK -> IDLE.
REQ-026 One strobe SHALL be outstanding at most; back-to-back throughput SHALL be one byte per SLRD_LOW+SLRD_HIGH+1 cycles.
REQ-027 Internal FIFO: 16 x 8, first-word-fall-through; rx_data valid while rx_valid=1; pop on rx_valid&rx_ready.
REQ-028 A push and a pop in the same cycle SHALL leave level unchanged and keep data order.
REQ-029 A push SHALL never occur at level=16 (guaranteed by the CHECK gate); a pop at level=0 SHALL be ignored.
REQ-030 Latency: byte captured at cycle N SHALL be on rx_data with rx_valid=1 at cycle N+1 if the FIFO was empty.

Reset
REQ-031 While sys_rst=1 at a sys_clk edge: state=IDLE, SLRD=1, SLOE=1, rx_valid=0, rx_data=0, level=0, byte_count=0, synchronizer=0.
REQ-032 A reset mid-strobe SHALL release SLRD to 1 on the next edge; the partial byte SHALL NOT be pushed.
REQ-033 FIFOADR outputs SHALL equal EP_ADDR during and after reset.

Verification
REQ-034 FX2 model holds 0x11,0x22,0x33, enable=1, rx_ready=1 -> exactly 3 SLRD pulses, each 3 cycles low; rx_data sequence 0x11,0x22,0x33; byte_count=3; FSM idles in CHECK.
REQ-035 FLAGA=0 throughout, enable=1 -> SLOE=0, SLRD stays 1, level=0, rx_valid=0.
REQ-036 rx_ready=0 with 20 bytes available -> 16 reads, level=16, SLRD stays 1; one pop -> exactly one more read, level back to 16.
REQ-037 enable falls on the 2nd RD_LOW cycle -> SLRD low for the full 3 cycles, byte pushed, then IDLE with SLOE=1.
REQ-038 sys_rst asserted on the 2nd RD_LOW cycle -> SLRD=1 and level=0 on the next edge; byte_count unchanged from 0.
REQ-039 byte_count preset path: 65536 reads -> byte_count wraps to 0; simultaneous push+pop at level=8 -> level stays 8.
